// File: rtl/seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_decoder_pkg
// Shared types and reset constants for the seq_decoder block.
//   state_e       : two-state sequencer encoding (IDLE=0, SWEEP=1)
//   RST_*         : reset values for the select, sweep counter and status flags
// -----------------------------------------------------------------------------
package seq_decoder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_e;

   localparam int   RST_OUT_VAL = 0;
   localparam int   RST_CNT_VAL = 0;
   localparam logic RST_FLAG    = 1'b0;

endpackage

// File: rtl/seq_decoder_onehot_decode.sv
// -----------------------------------------------------------------------------
// onehot_decode
// Combinational binary-to-one-hot decoder with enable.
// Ports:
//   addr   [ADDR_WIDTH-1:0] in  : index of the bit to set
//   en                      in  : when low the output is all-zero
//   onehot [N_OUT-1:0]      out : one-hot (or zero) select
// -----------------------------------------------------------------------------
module onehot_decode #(
   parameter int ADDR_WIDTH = 2,
   localparam int N_OUT = 1 << ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  en,
   output logic [N_OUT-1:0]      onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
// Registered address decoder with a built-in sweep sequencer. In IDLE the
// select follows enable/address one cycle later; a sweep_start walks the
// select through every output, one per clock, then pulses sweep_done.
// Optional feature macro: SEQ_DECODER_STALL_EN (adds sweep_stall, which
// freezes a sweep in place while high).
// Ports:
//   clk          in  : system clock, rising edge
//   reset        in  : synchronous active-high reset
//   enable       in  : normal-mode decode enable
//   address      in  : normal-mode select address [ADDR_WIDTH-1:0]
//   sweep_start  in  : sweep request, sampled only in IDLE
//   sweep_stall  in  : sweep hold (only with SEQ_DECODER_STALL_EN)
//   out          out : registered one-hot / all-zero select [N_OUT-1:0]
//   sweep_busy   out : high while sweeping
//   sweep_done   out : one-cycle pulse after the last sweep step
// -----------------------------------------------------------------------------
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   localparam int N_OUT = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  sweep_start,
`ifdef SEQ_DECODER_STALL_EN
   input  logic                  sweep_stall,
`endif
   output logic [N_OUT-1:0]      out,
   output logic                  sweep_busy,
   output logic                  sweep_done
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [N_OUT-1:0]      out_q, out_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  stall;
   logic                  last_step;
   logic                  use_seq;
   logic [ADDR_WIDTH-1:0] dec_addr;
   logic                  dec_en;
   logic [N_OUT-1:0]      dec_out;

`ifdef SEQ_DECODER_STALL_EN
   assign stall = sweep_stall;
`else
   assign stall = 1'b0;
`endif

   // The counter runs one ahead of the select, so it has wrapped to zero
   // exactly when the select shows the top bit: that is the final step.
   assign last_step = (cnt_q == '0);

   // Sequencer drives the decoder while a sweep step is being produced
   // (including the start cycle, where the counter is still zero).
   assign use_seq  = ((state_q == SWEEP) && !last_step) ||
                     ((state_q == IDLE)  && sweep_start);
   assign dec_addr = use_seq ? cnt_q : address;
   assign dec_en   = use_seq ? 1'b1  : enable;

   onehot_decode #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_decode (
      .addr   (dec_addr),
      .en     (dec_en),
      .onehot (dec_out)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= ADDR_WIDTH'(RST_CNT_VAL);
         out_q   <= N_OUT'(RST_OUT_VAL);
         busy_q  <= RST_FLAG;
         done_q  <= RST_FLAG;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sweep_start) state_d = SWEEP;
         SWEEP:   if (last_step && !stall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      out_d  = dec_out;
      cnt_d  = use_seq ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
      busy_d = (state_d == SWEEP);
      done_d = 1'b0;
      if ((state_q == SWEEP) && stall) begin
         out_d = out_q;
         cnt_d = cnt_q;
      end
      if ((state_q == SWEEP) && last_step && !stall) begin
         done_d = 1'b1;
      end
   end

   assign out        = out_q;
   assign sweep_busy = busy_q;
   assign sweep_done = done_q;

endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
// Directed, table-driven bench for seq_decoder (ADDR_WIDTH=2 main instance,
// plus an ADDR_WIDTH=3 instance for wide decode). Optional stall scenarios are
// compiled in with SEQ_DECODER_STALL_EN.
// -----------------------------------------------------------------------------
module tb_seq_decoder;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [1:0] address;
   logic       sweep_start;
   logic [3:0] out;
   logic       sweep_busy;
   logic       sweep_done;

   logic       enable3;
   logic [2:0] address3;
   logic [7:0] out3;
   logic       busy3;
   logic       done3;

`ifdef SEQ_DECODER_STALL_EN
   logic       sweep_stall;
   logic       stall3;
`endif

   int checks = 0;
   int errors = 0;

   seq_decoder #(.ADDR_WIDTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .address     (address),
      .sweep_start (sweep_start),
`ifdef SEQ_DECODER_STALL_EN
      .sweep_stall (sweep_stall),
`endif
      .out         (out),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done)
   );

   seq_decoder #(.ADDR_WIDTH(3)) dut3 (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable3),
      .address     (address3),
      .sweep_start (1'b0),
`ifdef SEQ_DECODER_STALL_EN
      .sweep_stall (stall3),
`endif
      .out         (out3),
      .sweep_busy  (busy3),
      .sweep_done  (done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] addr;
      logic       st;
      logic [3:0] exp_out;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eo, input logic eb, input logic ed);
      chk({tag, ".out"},  32'(out),        32'(eo));
      chk({tag, ".busy"}, 32'(sweep_busy), 32'(eb));
      chk({tag, ".done"}, 32'(sweep_done), 32'(ed));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst en addr st | out busy done  (expected after the edge)
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b1, 4'b0001, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0010, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0};

      reset = 1'b1; enable = 1'b0; address = '0; sweep_start = 1'b0;
      enable3 = 1'b0; address3 = '0;
`ifdef SEQ_DECODER_STALL_EN
      sweep_stall = 1'b0; stall3 = 1'b0;
`endif
      tick();

      // Table: reset, disabled decode, enabled decode, sweep, mid-sweep reset
      for (int i = 0; i < NV; i++) begin
         reset       = vecs[i].rst;
         enable      = vecs[i].en;
         address     = vecs[i].addr;
         sweep_start = vecs[i].st;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done);
      end

      // Wide decode on the ADDR_WIDTH=3 instance
      enable3 = 1'b1; address3 = 3'd5;
      tick();
      chk("w3.addr5", 32'(out3), 32'h20);
      address3 = 3'd7;
      tick();
      chk("w3.addr7", 32'(out3), 32'h80);
      enable3 = 1'b0;
      tick();
      chk("w3.off", 32'(out3), 32'h00);

      // sweep_start held through two sweeps: 4 steps + done, twice
      enable = 1'b1; address = 2'd2; sweep_start = 1'b1;
      for (int j = 0; j < 10; j++) begin
         tick();
         if ((j % 5) < 4)
            check_all($sformatf("held%0d", j), 4'(1 << (j % 5)), 1'b1, 1'b0);
         else
            check_all($sformatf("held%0d", j), 4'b0100, 1'b0, 1'b1);
      end
      sweep_start = 1'b0;
      for (int j = 10; j < 12; j++) begin
         tick();
         check_all($sformatf("held%0d", j), 4'b0100, 1'b0, 1'b0);
      end

`ifdef SEQ_DECODER_STALL_EN
      // Stall ignored in IDLE
      enable = 1'b1; address = 2'd1; sweep_stall = 1'b1;
      tick();
      check_all("idle_stall", 4'b0010, 1'b0, 1'b0);
      sweep_stall = 1'b0; enable = 1'b0;
      tick();

      // Stall 3 cycles while out=0010: busy spans 7 cycles
      sweep_start = 1'b1;
      tick();
      check_all("st0", 4'b0001, 1'b1, 1'b0);
      sweep_start = 1'b0;
      tick();
      check_all("st1", 4'b0010, 1'b1, 1'b0);
      sweep_stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check_all($sformatf("st_hold%0d", j), 4'b0010, 1'b1, 1'b0);
      end
      sweep_stall = 1'b0;
      tick();
      check_all("st5", 4'b0100, 1'b1, 1'b0);
      tick();
      check_all("st6", 4'b1000, 1'b1, 1'b0);
      tick();
      check_all("st7", 4'b0000, 1'b0, 1'b1);
      tick();
      check_all("st8", 4'b0000, 1'b0, 1'b0);

      // Stall on the last step delays sweep_done
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      tick(); tick(); tick();
      check_all("ls3", 4'b1000, 1'b1, 1'b0);
      sweep_stall = 1'b1;
      tick();
      check_all("ls_hold", 4'b1000, 1'b1, 1'b0);
      sweep_stall = 1'b0;
      tick();
      check_all("ls_done", 4'b0000, 1'b0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
